// File: rtl/io_pkg.sv
// Board I/O constants shared by the input conditioner and the computer's I/O decode.
package io_pkg;

    localparam int unsigned N_KEY_DEF           = 4;
    localparam int unsigned N_SW_DEF            = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

    // Counter width able to hold DEBOUNCE_CYCLES+2 (the settle terminal value).
    function automatic int unsigned cnt_width(input int unsigned debounce_cycles);
        return $clog2(debounce_cycles + 3);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchroniser, stability counter, accepted level and edge pulses.
module debounce_bit
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit          SYNC_RST        = 1'b0,
    parameter bit          INVERT          = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_pin,
    input  logic i_ready,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_change
);

    localparam int unsigned        CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_change;
    logic             w_sample;

    // Polarity fix-up sits after the synchroniser so the flop pair stays logic-free.
    assign w_sample = r_sync2 ^ INVERT;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1  <= SYNC_RST;
            r_sync2  <= SYNC_RST;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_change <= 1'b0;
        end else begin
            r_sync1  <= i_pin;
            r_sync2  <= r_sync1;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_change <= 1'b0;
            if (w_sample == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt    <= '0;
                r_level  <= w_sample;
                r_rise   <= i_ready & w_sample;
                r_fall   <= i_ready & ~w_sample;
                r_change <= i_ready;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level  = r_level;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_change = r_change;

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces KEY/SW pins; pulses are held off until the post-reset settle window ends.
module input_conditioner
    import io_pkg::*;
#(
    parameter int unsigned N_KEY           = N_KEY_DEF,
    parameter int unsigned N_SW            = N_SW_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_KEY-1:0] key_n_in,
    input  logic [N_SW-1:0]  sw_in,
    output logic [N_KEY-1:0] key_level,
    output logic [N_KEY-1:0] key_press,
    output logic [N_KEY-1:0] key_release,
    output logic [N_SW-1:0]  sw_level,
    output logic [N_SW-1:0]  sw_change,
    output logic             ready
);

    localparam int unsigned      CNT_W      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(DEBOUNCE_CYCLES + 2);

    logic [CNT_W-1:0] r_settle;
    logic             r_ready;
    logic [N_KEY-1:0] w_key_change_unused;
    logic [N_SW-1:0]  w_sw_rise_unused;
    logic [N_SW-1:0]  w_sw_fall_unused;

    // Settle window: long enough for levels held through reset to be accepted silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_settle <= '0;
            r_ready  <= 1'b0;
        end else if (r_settle != SETTLE_MAX) begin
            r_settle <= r_settle + CNT_W'(1);
            if (r_settle == SETTLE_MAX - CNT_W'(1)) begin
                r_ready <= 1'b1;
            end
        end
    end

    assign ready = r_ready;

    for (genvar g = 0; g < N_KEY; g++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_RST       (1'b1),
            .INVERT         (1'b1)
        ) u_db (
            .clock   (clock),
            .reset   (reset),
            .i_pin   (key_n_in[g]),
            .i_ready (r_ready),
            .o_level (key_level[g]),
            .o_rise  (key_press[g]),
            .o_fall  (key_release[g]),
            .o_change(w_key_change_unused[g])
        );
    end

    for (genvar g = 0; g < N_SW; g++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_RST       (1'b0),
            .INVERT         (1'b0)
        ) u_db (
            .clock   (clock),
            .reset   (reset),
            .i_pin   (sw_in[g]),
            .i_ready (r_ready),
            .o_level (sw_level[g]),
            .o_rise  (w_sw_rise_unused[g]),
            .o_fall  (w_sw_fall_unused[g]),
            .o_change(sw_change[g])
        );
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Synchronises and debounces the raw board inputs (KEY push-buttons, SW slide switches) before they reach sc_computer's memory-mapped I/O.
- Sits between the board pins and the computer's KEY/SW inputs.
- Provides clean active-high levels plus one-cycle press/release/change pulses, so software and I/O logic never see metastability or contact bounce.
- Runs on the PLL-derived system clock.

Parameters:
- N_KEY, 4, number of push-buttons (pins active-low).
- N_SW, 10, number of slide switches (pins active-high).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new level; legal range ≥2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+3), width of the per-bit and settle counters (derived; do not override).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- key_n_in  input  N_KEY  raw button pins, 0 = pressed, asynchronous to clock.
- sw_in  input  N_SW  raw switch pins, asynchronous to clock.
- key_level  output  N_KEY  debounced button state, 1 = pressed.
- key_press  output  N_KEY  one-cycle pulse per bit on accepted 0→1 of key_level.
- key_release  output  N_KEY  one-cycle pulse per bit on accepted 1→0 of key_level.
- sw_level  output  N_SW  debounced switch state.
- sw_change  output  N_SW  one-cycle pulse per bit on any accepted sw_level change.
- ready  output  1  high once the post-reset settle window has elapsed.

Behaviour:
- Reset values:
  - key sync flops = 1 (released); sw sync flops = 0.
  - All counters = 0.
  - key_level, sw_level, all pulses and ready = 0.
- Key inputs are inverted after synchronisation, so all internal logic is active-high.
- Synchroniser: two flops per bit, no logic between them. The second flop output is the "sample".
- Per-bit debounce, with stable = the level register:
  - sample == stable: counter <= 0.
  - sample != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sample != stable and counter == DEBOUNCE_CYCLES-1: stable <= sample, counter <= 0.
- Latency: a pin change held clean is visible on the level output exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
- Any single cycle of sample == stable during the count restarts the count. A bounce shorter than DEBOUNCE_CYCLES never changes the level.
- Pulses:
  - Registered, and asserted in the same cycle the new level first appears; high for exactly one cycle.
  - key_press / key_release follow direction; sw_change ignores direction.
- Settle counter counts from 0 after reset and saturates at DEBOUNCE_CYCLES+2. ready is set on the edge where it reaches that value and stays set until reset.
- Pulse masking:
  - A pulse is generated only if ready was already 1 before the flipping edge.
  - Level flips while ready == 0 update the level silently. This covers switches held during reset.
  - Levels are never masked.
- Bits are fully independent. Simultaneous accepted changes on any combination of bits pulse in the same cycle.
- Reset asserted mid-debounce: on the next edge, counters, levels, pulses and ready all clear and sync flops reload their reset values. Debounce restarts from scratch after reset deasserts.
- No other state or FSM; there is no cross-bit interaction.

Decomposition:
- Shared package io_pkg: default DEBOUNCE_CYCLES, N_KEY, N_SW constants (reused by sc_computer's I/O decode).
- Sub-module debounce_bit, parameterised by DEBOUNCE_CYCLES and a reset sync value. It contains the 2-flop sync, counter, level register and rise/fall pulse outputs, with ready as an enable input.
- Top instantiates N_KEY+N_SW copies via generate, plus the settle counter.

Test Plan (DEBOUNCE_CYCLES=4, reset released before edge 0):
- Idle reset, key_n_in=4'hF, sw_in=0 → all outputs 0; ready rises at edge 6 and stays 1; no pulses ever.
- key_n_in[1] driven 0 before edge 20 and held → key_level=4'b0010 from edge 26 and key_press=4'b0010 for that single cycle. Released before edge 40 → key_level=0 and key_release=4'b0010 at edge 46 only.
- key_n_in[2] low for 3 cycles, then high, repeated 5 times → key_level[2] stays 0, no pulses. A subsequent clean 4-cycle-plus hold → accepted.
- sw_in=10'h3FF held through reset → sw_level=10'h3FF at edge 6 with sw_change=0 throughout; ready=1 at edge 6.
- key_n_in[0]=0 and sw_in[3]=1 in the same cycle after ready → key_press[0] and sw_change[3] assert in the same cycle, one cycle wide.
- sw_in[5]=1 for 3 post-ready cycles, then reset pulsed for 1 cycle → next edge: all outputs 0 and ready=0. sw_level[5] rises silently 6 edges after reset deasserts with no sw_change.
